// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> little-endian 32-bit words into instruction memory.
// Holds the core in reset until every word of the image has been written.
module imem_loader #(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(IMEM_DEPTH);

    state_t      state, state_nx;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] wcnt;
    logic [1:0]  bidx;
    logic        xfer;
    logic        load_init;
    logic        len_bad;
    logic        last_word;
    logic [15:0] len_rx;

    assign xfer      = byte_valid && byte_ready;
    assign load_init = (state == S_IDLE) || (start && (state == S_DONE || state == S_ERR));
    assign len_rx    = {byte_data, len_lo};
    assign len_bad   = (len_rx == 16'd0) || ({1'b0, len_rx} > DEPTH_L);
    assign last_word = ((wcnt + 16'd1) == len);

    // All status outputs decode straight from the state register.
    assign byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
    assign busy       = byte_ready || (state == S_WRITE);
    assign imem_we    = (state == S_WRITE);
    assign cpu_rst    = (state != S_DONE);
    assign done       = (state == S_DONE);
    assign err        = (state == S_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_LEN_LO;
            S_LEN_LO: if (xfer) state_nx = S_LEN_HI;
            S_LEN_HI: if (xfer) state_nx = len_bad ? S_ERR : S_DATA;
            S_DATA:   if (xfer && bidx == 2'd3) state_nx = S_WRITE;
            S_WRITE:  state_nx = last_word ? S_DONE : S_DATA;
            S_DONE:   if (start) state_nx = S_LEN_LO;
            S_ERR:    if (start) state_nx = S_LEN_LO;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_lo     <= '0;
            len        <= '0;
            wcnt       <= '0;
            bidx       <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else if (load_init) begin
            wcnt      <= '0;
            bidx      <= '0;
            imem_addr <= '0;
        end else begin
            case (state)
                S_LEN_LO: if (xfer) len_lo <= byte_data;
                S_LEN_HI: if (xfer) len <= len_rx;
                S_DATA: if (xfer) begin
                    imem_wdata[8*bidx +: 8] <= byte_data;
                    bidx <= bidx + 2'd1;
                end
                S_WRITE: begin
                    wcnt <= wcnt + 16'd1;
                    // Address stays on the last word so a full-depth image never wraps to 0.
                    if (!last_word) imem_addr <= imem_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader; a byte-level image model predicts the words, addresses and timing.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst, start, byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready, imem_we, cpu_rst, busy, done, err;
    logic [7:0] imem_addr;
    logic [31:0] imem_wdata;

    always #5 clk = ~clk;

    imem_loader #(.IMEM_DEPTH(256), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    int n_chk = 0, n_fail = 0;
    int cyc_cnt = 0;
    logic [7:0]  wq_addr[$];
    logic [31:0] wq_data[$];

    always @(posedge clk) cyc_cnt++;
    always @(negedge clk) if (imem_we === 1'b1) begin
        wq_addr.push_back(imem_addr);
        wq_data.push_back(imem_wdata);
    end

    // Reference model: header length, validity, and the words a correct loader must write.
    function automatic int img_len(input logic [7:0] img[$]);
        return int'(img[0]) + 256 * int'(img[1]);
    endfunction

    function automatic bit img_bad(input logic [7:0] img[$]);
        int l = img_len(img);
        return (l == 0) || (l > 256);
    endfunction

    function automatic logic [31:0] img_word(input logic [7:0] img[$], input int k);
        int unsigned w = 0;
        for (int j = 0; j < 4; j++) w += int'(img[2 + 4*k + j]) * (1 << (8*j));
        return 32'(w);
    endfunction

    function automatic void make_image(input int n, output logic [7:0] img[$]);
        img = {};
        img.push_back(8'(n % 256));
        img.push_back(8'(n / 256));
        for (int i = 0; i < 4*n; i++) img.push_back(8'($urandom));
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_bytes(input logic [7:0] q[$], input int stall_pct, input int start_at,
                               output bit to);
        int i = 0;
        int budget = 20 * q.size() + 50;
        bit acc;
        to = 0;
        while (i < q.size()) begin
            if (budget == 0) begin to = 1; break; end
            budget--;
            byte_valid = ($urandom_range(99) >= stall_pct);
            byte_data  = byte_valid ? q[i] : 8'($urandom);
            start      = (i == start_at);
            @(negedge clk);
            acc = byte_valid && byte_ready;
            @(posedge clk); #1;
            if (acc) i++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    // Cycles are counted from the edge that enters LEN_LO until done/err is seen.
    task automatic run_load(input logic [7:0] img[$], input bit do_start, input int stall_pct,
                            input int start_at, output int cyc, output bit to);
        int t0, budget;
        bit dto;
        if (do_start) pulse_start();
        t0 = cyc_cnt;
        drive_bytes(img, stall_pct, start_at, dto);
        budget = 100;
        while (!(done || err) && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        to  = dto || (budget == 0);
        cyc = cyc_cnt - t0;
    endtask

    task automatic check_writes(input string tag, input logic [7:0] img[$]);
        int n = img_bad(img) ? 0 : img_len(img);
        n_chk++;
        if (wq_addr.size() !== n) begin
            n_fail++;
            $display("FAIL %s write_count got %0d exp %0d", tag, wq_addr.size(), n);
        end
        for (int k = 0; k < n && k < wq_addr.size(); k++) begin
            n_chk++;
            if (wq_addr[k] !== 8'(k) || wq_data[k] !== img_word(img, k)) begin
                n_fail++;
                $display("FAIL %s write[%0d] got %h@%0d exp %h@%0d", tag, k, wq_data[k], wq_addr[k],
                         img_word(img, k), k);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({cpu_rst, busy, done, err, byte_ready, imem_we} !== 6'b100000 ||
            imem_addr !== 8'd0 || imem_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset got rst/busy/done/err/rdy/we=%b addr=%0d wdata=%h exp 100000 0 0",
                     {cpu_rst, busy, done, err, byte_ready, imem_we}, imem_addr, imem_wdata);
        end
    endtask

    task automatic test_basic();
        logic [7:0] img[$] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        int cyc; bit to;
        wq_addr = {}; wq_data = {};
        @(posedge clk); #1;
        run_load(img, 1, 0, -1, cyc, to);
        n_chk++;
        if (to || cyc !== 2 + 5*img_len(img)) begin
            n_fail++;
            $display("FAIL basic_latency got %0d (timeout=%0b) exp %0d", cyc, to, 2 + 5*img_len(img));
        end
        check_writes("basic", img);
        n_chk++;
        if (wq_data.size() < 2 || wq_data[0] !== 32'h00A00513 || wq_data[1] !== 32'h00100593) begin
            n_fail++;
            $display("FAIL basic_words got %0d words exp 00a00513,00100593", wq_data.size());
        end
        n_chk++;
        if ({done, cpu_rst, busy, err} !== 4'b1000) begin
            n_fail++;
            $display("FAIL basic_status got done/cpu_rst/busy/err=%b exp 1000", {done, cpu_rst, busy, err});
        end
    endtask

    // Bad headers; the second one is launched by a start that coincides with an offered byte in ERR.
    task automatic test_bad_len();
        logic [7:0] h0[$] = '{8'h00, 8'h00};
        logic [7:0] h1[$] = '{8'h01, 8'h01};
        int cyc; bit to;
        wq_addr = {}; wq_data = {};
        run_load(h0, 1, 0, -1, cyc, to);
        n_chk++;
        if (to || {err, cpu_rst, byte_ready, busy, done} !== 5'b11000) begin
            n_fail++;
            $display("FAIL badlen_zero got err/cpu_rst/rdy/busy/done=%b timeout=%0b exp 11000",
                     {err, cpu_rst, byte_ready, busy, done}, to);
        end
        byte_valid = 1'b1; byte_data = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0; start = 1'b0;
        n_chk++;
        if ({err, busy, byte_ready} !== 3'b011) begin
            n_fail++;
            $display("FAIL err_restart got err/busy/rdy=%b exp 011", {err, busy, byte_ready});
        end
        run_load(h1, 0, 0, -1, cyc, to);
        repeat (3) @(posedge clk); #1;
        n_chk++;
        if (to || {err, cpu_rst, byte_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL badlen_257 got err/cpu_rst/rdy=%b timeout=%0b exp 110",
                     {err, cpu_rst, byte_ready}, to);
        end
        n_chk++;
        if (wq_addr.size() !== 0) begin
            n_fail++;
            $display("FAIL badlen_writes got %0d exp 0", wq_addr.size());
        end
    endtask

    task automatic test_stall();
        logic [7:0] img[$];
        int cyc; bit to;
        for (int r = 0; r < 3; r++) begin
            make_image(1 + r, img);
            wq_addr = {}; wq_data = {};
            run_load(img, 1, 50, -1, cyc, to);
            n_chk++;
            if (to || done !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_done got done=%b timeout=%0b exp 1", done, to);
            end
            check_writes("stall", img);
        end
    endtask

    task automatic test_random();
        logic [7:0] img[$];
        int cyc; bit to;
        for (int r = 0; r < 4; r++) begin
            make_image($urandom_range(8, 1), img);
            wq_addr = {}; wq_data = {};
            run_load(img, 1, $urandom_range(60, 0), -1, cyc, to);
            n_chk++;
            if (to || {done, cpu_rst} !== 2'b10) begin
                n_fail++;
                $display("FAIL random_done got done/cpu_rst=%b timeout=%0b exp 10", {done, cpu_rst}, to);
            end
            check_writes("random", img);
        end
    endtask

    task automatic test_max_len();
        logic [7:0] img[$];
        int cyc; bit to;
        make_image(256, img);
        wq_addr = {}; wq_data = {};
        run_load(img, 1, 0, -1, cyc, to);
        n_chk++;
        if (to || cyc !== 2 + 5*256 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL maxlen_latency got %0d done=%b timeout=%0b exp %0d", cyc, done, to, 2 + 5*256);
        end
        check_writes("maxlen", img);
    endtask

    task automatic test_abort_reload();
        logic [7:0] img[$];
        logic [7:0] part[$];
        int cyc; bit to;
        make_image(3, img);
        part = img[0:3];
        wq_addr = {}; wq_data = {};
        pulse_start();
        drive_bytes(part, 0, -1, to);
        rst = 1'b1;
        #1;
        n_chk++;
        if ({cpu_rst, busy, done, err, byte_ready, imem_we} !== 6'b100000 || imem_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_reset got rst/busy/done/err/rdy/we=%b addr=%0d exp 100000 0",
                     {cpu_rst, busy, done, err, byte_ready, imem_we}, imem_addr);
        end
        @(posedge clk); #1 rst = 1'b0;
        make_image(4, img);
        wq_addr = {}; wq_data = {};
        run_load(img, 1, 20, -1, cyc, to);
        n_chk++;
        if (to || done !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_done got done=%b timeout=%0b exp 1", done, to);
        end
        check_writes("reload", img);
    endtask

    task automatic test_start_mid();
        logic [7:0] img[$];
        int cyc; bit to;
        make_image(3, img);
        wq_addr = {}; wq_data = {};
        run_load(img, 1, 0, 7, cyc, to);
        n_chk++;
        if (to || cyc !== 2 + 5*3) begin
            n_fail++;
            $display("FAIL startmid_latency got %0d timeout=%0b exp %0d", cyc, to, 2 + 5*3);
        end
        check_writes("startmid", img);
    endtask

    // Start from DONE with a byte offered on the same cycle; that byte must not be consumed.
    task automatic test_restart_done();
        logic [7:0] img[$];
        int cyc; bit to;
        byte_valid = 1'b1; byte_data = 8'hFF; start = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({done, byte_ready, cpu_rst} !== 3'b100) begin
            n_fail++;
            $display("FAIL done_hold got done/rdy/cpu_rst=%b exp 100", {done, byte_ready, cpu_rst});
        end
        @(posedge clk); #1;
        byte_valid = 1'b0; start = 1'b0;
        n_chk++;
        if ({cpu_rst, done, busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL restart_edge got cpu_rst/done/busy=%b exp 101", {cpu_rst, done, busy});
        end
        make_image(2, img);
        wq_addr = {}; wq_data = {};
        run_load(img, 0, 0, -1, cyc, to);
        n_chk++;
        if (to || cyc !== 2 + 5*2) begin
            n_fail++;
            $display("FAIL restart_latency got %0d timeout=%0b exp %0d", cyc, to, 2 + 5*2);
        end
        check_writes("restart", img);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restart_done();
        test_bad_len();
        test_stall();
        test_random();
        test_start_mid();
        test_abort_reload();
        test_max_len();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
